branch_predictor: RTL and testbench

- Parametrised branch target buffer with per-entry saturating direction counters for the IF stage.
- Replaces the fixed predict-not-taken and resolve-in-EX behaviour of the current 5-stage pipeline.
- IF gets a combinational next-PC prediction each cycle. EX reports resolved branches and jumps. The block flags mispredictions for redirect and keeps performance counters.

---
 rtl/branch_predictor_if.sv | 36 +++
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, execute-side resolution and perf-counter signals
// between the pipeline and the branch target buffer.
interface branch_predictor_if #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
);
    logic              flush_all;
    logic [XLEN-1:0]   if_pc;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_is_jump;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [XLEN-1:0]   upd_pred_target;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;
    logic [PERF_W-1:0] perf_updates;
    logic [PERF_W-1:0] perf_mispredicts;

    modport master (
        output flush_all, if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               perf_updates, perf_mispredicts
    );

    modport slave (
        input  flush_all, if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               perf_updates, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters:
// zero-latency next-PC prediction for IF, resolution and redirect from EX.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int PERF_W   = 32
) (
    input logic              clk,
    input logic              rst,
    branch_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [PERF_W-1:0]   PERF_MAX = {PERF_W{1'b1}};

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [ENTRIES-1:0]  jump_q;
    logic [PERF_W-1:0]   perf_upd_q;
    logic [PERF_W-1:0]   perf_mis_q;

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;
    logic                lk_taken;
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0] up_tag;
    logic                up_hit;
    logic                mispredict_w;

    assign lk_idx   = bus.if_pc[IDX_BITS+1:2];
    assign lk_tag   = bus.if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][CTR_BITS-1]);

    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_taken ? target_q[lk_idx] : bus.if_pc + XLEN'(4);

    assign up_idx = bus.upd_pc[IDX_BITS+1:2];
    assign up_tag = bus.upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign mispredict_w = bus.upd_valid &&
                          ((bus.upd_pred_taken != bus.upd_taken) ||
                           (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));

    assign bus.mispredict       = mispredict_w;
    assign bus.redirect_pc      = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);
    assign bus.perf_updates     = perf_upd_q;
    assign bus.perf_mispredicts = perf_mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            jump_q     <= '0;
            perf_upd_q <= '0;
            perf_mis_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            if (bus.flush_all) begin
                valid_q <= '0;
            end
            if (bus.upd_valid) begin
                if (up_hit) begin
                    if (bus.upd_taken) begin
                        if (ctr_q[up_idx] != CTR_MAX) begin
                            ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
                        end
                        target_q[up_idx] <= bus.upd_target;
                        jump_q[up_idx]   <= bus.upd_is_jump;
                    end else if (ctr_q[up_idx] != '0) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
                    end
                end else if (bus.upd_taken && !bus.flush_all) begin
                    // Miss on a taken branch: evict whatever lives at this index.
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= bus.upd_target;
                    jump_q[up_idx]   <= bus.upd_is_jump;
                    ctr_q[up_idx]    <= CTR_INIT;
                end
                if (perf_upd_q != PERF_MAX) begin
                    perf_upd_q <= perf_upd_q + PERF_W'(1);
                end
                if (mispredict_w && (perf_mis_q != PERF_MAX)) begin
                    perf_mis_q <= perf_mis_q + PERF_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (PERF_W=4 build) with an expected-value queue.
module tb_branch_predictor;
    localparam int XLEN   = 32;
    localparam int PERF_W = 4;

    logic clk = 1'b0;
    logic rst;

    branch_predictor_if #(.XLEN(XLEN), .PERF_W(PERF_W)) bus ();

    branch_predictor #(
        .XLEN(XLEN), .IDX_BITS(4), .TAG_BITS(8), .CTR_BITS(2), .PERF_W(PERF_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_upd = 0;
    int   exp_mispred = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard_empty: observed %0h with no expected value", obs);
        end else begin
            e = sb_q.pop_front();
            n_cmp++;
            assert (obs === e.exp) else begin
                n_mis++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bus.if_pc = pc;
        push($sformatf("pred_taken@%0h", pc), {31'd0, taken});
        push($sformatf("pred_target@%0h", pc), tgt);
        #1;
        check({31'd0, bus.pred_taken});
        check(bus.pred_target);
    endtask

    task automatic perf_chk();
        push("perf_updates", exp_upd);
        push("perf_mispredicts", exp_mispred);
        check({28'd0, bus.perf_updates});
        check({28'd0, bus.perf_mispredicts});
    endtask

    task automatic do_update(input logic [31:0] pc, input logic jump, input logic taken,
                             input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt,
                             input logic exp_mp, input logic [31:0] exp_redir, input logic flush);
        bus.upd_valid       = 1'b1;
        bus.upd_pc          = pc;
        bus.upd_is_jump     = jump;
        bus.upd_taken       = taken;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = ptaken;
        bus.upd_pred_target = ptgt;
        bus.flush_all       = flush;
        push($sformatf("mispredict@%0h", pc), {31'd0, exp_mp});
        push($sformatf("redirect_pc@%0h", pc), exp_redir);
        #1;
        check({31'd0, bus.mispredict});
        check(bus.redirect_pc);
        @(posedge clk);
        if (exp_upd != 15) exp_upd++;
        if (exp_mp && exp_mispred != 15) exp_mispred++;
        #1;
        bus.upd_valid = 1'b0;
        bus.flush_all = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        bus.flush_all       = 1'b0;
        bus.if_pc           = 32'h100;
        bus.upd_valid       = 1'b0;
        bus.upd_pc          = '0;
        bus.upd_is_jump     = 1'b0;
        bus.upd_taken       = 1'b0;
        bus.upd_target      = '0;
        bus.upd_pred_taken  = 1'b0;
        bus.upd_pred_target = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        look(32'h100, 1'b0, 32'h104);
        perf_chk();
        push("mispredict_idle", 32'd0);
        check({31'd0, bus.mispredict});

        // Branch at 0x200: allocate weakly taken, then walk the counter.
        do_update(32'h200, 0, 1, 32'h180, 0, 32'h0,   1, 32'h180, 0);
        look(32'h200, 1'b1, 32'h180);
        do_update(32'h200, 0, 0, 32'h180, 1, 32'h180, 1, 32'h204, 0);
        look(32'h200, 1'b0, 32'h204);
        do_update(32'h200, 0, 0, 32'h180, 0, 32'h0,   0, 32'h204, 0);
        do_update(32'h200, 0, 0, 32'h180, 0, 32'h0,   0, 32'h204, 0);
        do_update(32'h200, 0, 1, 32'h180, 0, 32'h0,   1, 32'h180, 0);
        look(32'h200, 1'b0, 32'h204);
        do_update(32'h200, 0, 1, 32'h180, 0, 32'h0,   1, 32'h180, 0);
        look(32'h200, 1'b1, 32'h180);
        do_update(32'h200, 0, 1, 32'h180, 1, 32'h180, 0, 32'h180, 0);
        do_update(32'h200, 0, 1, 32'h180, 1, 32'h180, 0, 32'h180, 0);
        do_update(32'h200, 0, 0, 32'h180, 1, 32'h180, 1, 32'h204, 0);
        look(32'h200, 1'b1, 32'h180);
        perf_chk();

        // jal keeps predicting taken even after a not-taken update; aliases miss.
        do_update(32'h300, 1, 1, 32'h400, 0, 32'h0,   1, 32'h400, 0);
        do_update(32'h300, 0, 0, 32'h400, 1, 32'h400, 1, 32'h304, 0);
        look(32'h300, 1'b1, 32'h400);
        look(32'h340, 1'b0, 32'h344);

        // Flush coinciding with a taken update: no allocation, update still counted.
        do_update(32'h500, 0, 1, 32'h600, 0, 32'h0,   1, 32'h600, 1);
        look(32'h500, 1'b0, 32'h504);
        look(32'h300, 1'b0, 32'h304);
        perf_chk();

        // Correct predictions drive perf_updates into saturation.
        do_update(32'h208, 0, 1, 32'h800, 0, 32'h0,   1, 32'h800, 0);
        for (int i = 0; i < 20; i++) begin
            do_update(32'h208, 0, 1, 32'h800, 1, 32'h800, 0, 32'h800, 0);
        end
        perf_chk();
        look(32'h208, 1'b1, 32'h800);

        // Asynchronous reset mid-update, checked before the next clock edge.
        bus.upd_valid       = 1'b1;
        bus.upd_pc          = 32'h208;
        bus.upd_taken       = 1'b1;
        bus.upd_target      = 32'h800;
        bus.upd_pred_taken  = 1'b0;
        #1 rst = 1'b1;
        exp_upd     = 0;
        exp_mispred = 0;
        #1;
        perf_chk();
        look(32'h208, 1'b0, 32'h20c);
        bus.upd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        look(32'h100, 1'b0, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
